// File: rtl/lift_scheduler_pkg.sv
// Shared types for the lift scheduler slice: FSM states, travel direction
// and the floor-index width helper also used by door_controller.
package lift_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    ARRIVE    = 3'd3,
    DOOR_WAIT = 3'd4
  } lift_state_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } lift_dir_e;

  // A single-floor building still needs a one-bit index.
  function automatic int floor_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lift_scheduler_if.sv
// Call/door/status bundle between the scheduler (slave) and the
// environment that raises calls and reports the door (master).
interface lift_scheduler_if #(
  parameter int N_FLOORS = 12,
  parameter int FLOOR_W  = lift_pkg::floor_w(N_FLOORS)
);

  logic [N_FLOORS-1:0] call_req;
  logic                door_open;
  logic                arrive_pulse;
  logic [FLOOR_W-1:0]  cur_floor;
  logic                moving_up;
  logic                moving_down;
  logic [N_FLOORS-1:0] pending;

  modport master (
    output call_req, door_open,
    input  arrive_pulse, cur_floor, moving_up, moving_down, pending
  );

  modport slave (
    input  call_req, door_open,
    output arrive_pulse, cur_floor, moving_up, moving_down, pending
  );

endinterface

// File: rtl/lift_scheduler_travel_timer.sv
// Per-floor travel counter; floor_done_o marks the last cycle of a floor
// and the counter wraps to zero on that cycle while enabled.
module floor_travel_timer #(
  parameter int unsigned FLOOR_TRAVEL_CYCLES = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic floor_done_o
);

  logic [31:0] count_q, count_d;

  assign floor_done_o = (count_q == 32'(FLOOR_TRAVEL_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = floor_done_o ? '0 : count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lift_scheduler.sv
// Collective (SCAN) car scheduler: latches calls, steps the car one floor
// per travel period and hands each served floor to the door controller.
module lift_scheduler
  import lift_pkg::*;
#(
  parameter int          N_FLOORS            = 12,
  parameter int unsigned FLOOR_TRAVEL_CYCLES = 100,
  parameter int          FLOOR_W             = floor_w(N_FLOORS)
) (
  input  logic            clk,
  input  logic            reset,
  lift_scheduler_if.slave bus
);

  lift_state_e         state_q, state_d;
  lift_dir_e           dir_q, dir_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic                door_seen_q, door_seen_d;

  logic                timer_clear, timer_enable, floor_done;
  logic [FLOOR_W-1:0]  step_floor;
  logic [N_FLOORS-1:0] above_mask, below_mask, beyond_mask;
  logic                calls_above, calls_below, calls_beyond;

  floor_travel_timer #(
    .FLOOR_TRAVEL_CYCLES(FLOOR_TRAVEL_CYCLES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (timer_clear),
    .enable_i    (timer_enable),
    .floor_done_o(floor_done)
  );

  // Floor the car reaches at the end of the current travel period, and the
  // call masks relative to the current floor and to that next floor.
  always_comb begin
    step_floor = (state_q == MOVE_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
    above_mask  = '0;
    below_mask  = '0;
    beyond_mask = '0;
    for (int f = 0; f < N_FLOORS; f++) begin
      above_mask[f]  = (f > int'(floor_q));
      below_mask[f]  = (f < int'(floor_q));
      beyond_mask[f] = (state_q == MOVE_DOWN) ? (f < int'(step_floor)) : (f > int'(step_floor));
    end
    calls_above  = |(pending_q & above_mask);
    calls_below  = |(pending_q & below_mask);
    calls_beyond = |(pending_q & beyond_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= UP;
      floor_q     <= '0;
      pending_q   <= '0;
      door_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      floor_q     <= floor_d;
      pending_q   <= pending_d;
      door_seen_q <= door_seen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    floor_d      = floor_q;
    door_seen_d  = door_seen_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    pending_d    = pending_q | bus.call_req;

    unique case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          state_d = ARRIVE;
        end else if (calls_above && (dir_q == UP || !calls_below)) begin
          state_d     = MOVE_UP;
          dir_d       = UP;
          timer_clear = 1'b1;
        end else if (calls_below) begin
          state_d     = MOVE_DOWN;
          dir_d       = DOWN;
          timer_clear = 1'b1;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        timer_enable = 1'b1;
        if (floor_done) begin
          floor_d = step_floor;
          if (pending_q[step_floor]) begin
            state_d = ARRIVE;
          end else if (!calls_beyond) begin
            state_d = IDLE;
          end
        end
      end

      // Clearing here beats a same-cycle call for this floor.
      ARRIVE: begin
        pending_d[floor_q] = 1'b0;
        state_d            = DOOR_WAIT;
        if (bus.door_open) begin
          door_seen_d = 1'b1;
        end
      end

      DOOR_WAIT: begin
        if (door_seen_q && !bus.door_open) begin
          door_seen_d = 1'b0;
          state_d     = IDLE;
        end else if (bus.door_open) begin
          door_seen_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.arrive_pulse = (state_q == ARRIVE);
    bus.moving_up    = (state_q == MOVE_UP);
    bus.moving_down  = (state_q == MOVE_DOWN);
    bus.cur_floor    = floor_q;
    bus.pending      = pending_q;
  end

  // The direction policy must never step the car past either end shaft.
  assert property (@(posedge clk) disable iff (reset)
    (state_q == MOVE_UP && floor_done) |-> (int'(floor_q) < N_FLOORS - 1));
  assert property (@(posedge clk) disable iff (reset)
    (state_q == MOVE_DOWN && floor_done) |-> (floor_q != '0));

endmodule
